// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, flag bit positions and the
// sharing-controller FSM states.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 24;
  localparam int unsigned ALU_OPW   = 3;

  localparam logic [ALU_OPW-1:0] ADD   = 3'd0;
  localparam logic [ALU_OPW-1:0] SUB   = 3'd1;
  localparam logic [ALU_OPW-1:0] SUB_R = 3'd2;
  localparam logic [ALU_OPW-1:0] INC   = 3'd3;
  localparam logic [ALU_OPW-1:0] AND   = 3'd4;
  localparam logic [ALU_OPW-1:0] OR    = 3'd5;
  localparam logic [ALU_OPW-1:0] XOR   = 3'd6;
  localparam logic [ALU_OPW-1:0] EQ    = 3'd7;

  localparam int unsigned C_FLAG = 2;
  localparam int unsigned Z_FLAG = 1;
  localparam int unsigned N_FLAG = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: on a tie the requester that was not served
// last wins; a lone requester always wins.
module rr_arb2 (
  input  logic [1:0] req_valid,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  always_comb begin
    gnt_valid = |req_valid;
    if (&req_valid) begin
      gnt_idx = ~last;
    end else begin
      gnt_idx = req_valid[1];
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Time-shares one combinational ALU between two requesters: accept in IDLE,
// drive the ALU from captured operands in ISSUE, hold the result in RESP.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned OPW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [OPW-1:0]   req_op0,
  input  logic [OPW-1:0]   req_op1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [2:0]       rsp_flags,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_sel,
  output logic             alu_carry_in,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [2:0]       alu_flags,
  output logic             busy
);

  state_e           state_q;
  logic             last_q;
  logic             owner_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [OPW-1:0]   op_q;
  logic [WIDTH-1:0] result_q;
  logic [2:0]       flags_q;
  logic [1:0]       rsp_valid_q;
  logic             busy_q;

  logic gnt_valid;
  logic gnt_idx;

  rr_arb2 u_arb (
    .req_valid (req_valid),
    .last      (last_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Accept is offered only while idle; the one path from inputs to outputs.
  always_comb begin
    req_ready = 2'b00;
    if (state_q == IDLE && gnt_valid) begin
      req_ready = gnt_idx ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      result_q    <= '0;
      flags_q     <= '0;
      rsp_valid_q <= 2'b00;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_valid) begin
            a_q     <= gnt_idx ? req_a1 : req_a0;
            b_q     <= gnt_idx ? req_b1 : req_b0;
            op_q    <= gnt_idx ? req_op1 : req_op0;
            owner_q <= gnt_idx;
            busy_q  <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          result_q    <= alu_result;
          flags_q     <= alu_flags;
          last_q      <= owner_q;
          rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
          state_q     <= RESP;
        end
        RESP: begin
          // Leave through IDLE so nothing is accepted on the consume edge.
          if (rsp_ready[owner_q]) begin
            rsp_valid_q <= 2'b00;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 2'b00;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_result   = result_q;
  assign rsp_flags    = flags_q;
  assign alu_a        = a_q;
  assign alu_b        = b_q;
  assign alu_sel      = op_q;
  assign alu_carry_in = 1'b0;
  assign busy         = busy_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl with a behavioural ALU on the
// alu_* port and a response scoreboard.
module tb_alu_share_ctrl;
  import alu_pkg::*;

  localparam int unsigned W = 24;

  logic         clk;
  logic         rst_n;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [W-1:0] req_a0, req_a1, req_b0, req_b1;
  logic [2:0]   req_op0, req_op1;
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_ready;
  logic [W-1:0] rsp_result;
  logic [2:0]   rsp_flags;
  logic [W-1:0] alu_a, alu_b;
  logic [2:0]   alu_sel;
  logic         alu_carry_in;
  logic [W-1:0] alu_result;
  logic [2:0]   alu_flags;
  logic         busy;
  logic [W:0]   alu_wide;

  int n_cmp;
  int n_err;

  typedef struct {
    logic [1:0]   owner;
    logic [W-1:0] res;
    logic [2:0]   fl;
  } exp_t;
  exp_t sb[$];

  alu_share_ctrl #(.WIDTH(W), .OPW(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a0       (req_a0),
    .req_a1       (req_a1),
    .req_b0       (req_b0),
    .req_b1       (req_b1),
    .req_op0      (req_op0),
    .req_op1      (req_op1),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_flags    (rsp_flags),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_sel      (alu_sel),
    .alu_carry_in (alu_carry_in),
    .alu_result   (alu_result),
    .alu_flags    (alu_flags),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU: C is carry for add/inc and borrow for subtracts.
  always_comb begin
    alu_wide = '0;
    case (alu_sel)
      ADD:     alu_wide = {1'b0, alu_a} + {1'b0, alu_b} + {{W{1'b0}}, alu_carry_in};
      SUB:     alu_wide = {1'b0, alu_a} - {1'b0, alu_b};
      SUB_R:   alu_wide = {1'b0, alu_b} - {1'b0, alu_a};
      INC:     alu_wide = {1'b0, alu_a} + 25'd1;
      AND:     alu_wide = {1'b0, alu_a & alu_b};
      OR:      alu_wide = {1'b0, alu_a | alu_b};
      XOR:     alu_wide = {1'b0, alu_a ^ alu_b};
      default: alu_wide = 25'(alu_a == alu_b);
    endcase
    alu_result = alu_wide[W-1:0];
    alu_flags  = {alu_wide[W], alu_result == '0, alu_result[W-1]};
  end

  task automatic test_reset;
    logic [83:0] obs;
    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
    req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0; req_op0 = '0; req_op1 = '0;
    #2;
    obs = {req_ready, rsp_valid, rsp_result, rsp_flags, alu_a, alu_b, alu_sel, busy, alu_carry_in};
    n_cmp++;
    if (obs !== 84'd0) begin
      n_err++; $display("FAIL reset_outputs: got %h want 0", obs);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_add;
    exp_t e;
    @(negedge clk);
    req_valid = 2'b01; req_a0 = 24'd5; req_b0 = 24'd3; req_op0 = ADD; #1;
    n_cmp++;
    if (req_ready !== 2'b01) begin
      n_err++; $display("FAIL add_ready: got %b want 01", req_ready);
    end
    sb.push_back('{owner: 2'b01, res: 24'h000008, fl: 3'b000});
    @(negedge clk); req_valid = 2'b00; #1;
    n_cmp++;
    if ({busy, rsp_valid, alu_a, alu_b, alu_sel} !== {1'b1, 2'b00, 24'd5, 24'd3, ADD}) begin
      n_err++; $display("FAIL add_issue: got busy=%b rv=%b a=%h b=%h sel=%0d want 1 00 5 3 0",
                        busy, rsp_valid, alu_a, alu_b, alu_sel);
    end
    @(negedge clk); rsp_ready = 2'b01; #1;
    e = sb.pop_front();
    n_cmp++;
    if ({rsp_valid, rsp_result, rsp_flags} !== {e.owner, e.res, e.fl}) begin
      n_err++; $display("FAIL add_rsp: got %b %h %b want %b %h %b",
                        rsp_valid, rsp_result, rsp_flags, e.owner, e.res, e.fl);
    end
    @(negedge clk); rsp_ready = 2'b00; #1;
    n_cmp++;
    if ({busy, rsp_valid} !== 3'b000) begin
      n_err++; $display("FAIL add_done: got busy=%b rv=%b want 0 00", busy, rsp_valid);
    end
  endtask

  // Requester 1 subtract with borrow; requester 0 pulses valid while busy.
  task automatic test_sub_drop;
    exp_t e;
    @(negedge clk);
    req_valid = 2'b10; req_a1 = 24'd3; req_b1 = 24'd5; req_op1 = SUB; #1;
    n_cmp++;
    if (req_ready !== 2'b10) begin
      n_err++; $display("FAIL sub_ready: got %b want 10", req_ready);
    end
    sb.push_back('{owner: 2'b10, res: 24'hFFFFFE, fl: 3'b101});
    @(negedge clk); req_valid = 2'b01; req_a0 = 24'd9; req_b0 = 24'd1; req_op0 = OR; #1;
    n_cmp++;
    if (req_ready !== 2'b00) begin
      n_err++; $display("FAIL sub_wait: got %b want 00", req_ready);
    end
    @(negedge clk); req_valid = 2'b00; rsp_ready = 2'b10; #1;
    e = sb.pop_front();
    n_cmp++;
    if ({rsp_valid, rsp_result, rsp_flags} !== {e.owner, e.res, e.fl}) begin
      n_err++; $display("FAIL sub_rsp: got %b %h %b want %b %h %b",
                        rsp_valid, rsp_result, rsp_flags, e.owner, e.res, e.fl);
    end
    @(negedge clk); rsp_ready = 2'b00;
    @(negedge clk); #1;
    n_cmp++;
    if ({busy, req_ready, rsp_valid} !== 5'b00000) begin
      n_err++; $display("FAIL drop_no_grant: got busy=%b rr=%b rv=%b want 0", busy, req_ready, rsp_valid);
    end
  endtask

  task automatic test_contention;
    exp_t e;
    int   ngr;
    logic [1:0] exp_g;
    ngr = 0;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) begin
        req_valid = 2'b11; rsp_ready = 2'b11;
        req_a0 = 24'd7; req_b0 = 24'd7; req_op0 = SUB;
        req_a1 = 24'hFFFFFF; req_b1 = 24'd0; req_op1 = INC;
      end
      #1;
      if (rsp_valid !== 2'b00) begin
        n_cmp++;
        if (req_ready !== 2'b00) begin
          n_err++; $display("FAIL cont_no_accept: got %b want 00 at cycle %0d", req_ready, i);
        end
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL cont_unexpected_rsp: got rv=%b want none at cycle %0d", rsp_valid, i);
        end else begin
          e = sb.pop_front();
          if ({rsp_valid, rsp_result, rsp_flags} !== {e.owner, e.res, e.fl}) begin
            n_err++; $display("FAIL cont_rsp: got %b %h %b want %b %h %b",
                              rsp_valid, rsp_result, rsp_flags, e.owner, e.res, e.fl);
          end
        end
      end else if (req_ready !== 2'b00) begin
        exp_g = (ngr % 2 == 0) ? 2'b01 : 2'b10;
        n_cmp++;
        if (req_ready !== exp_g) begin
          n_err++; $display("FAIL cont_grant: got %b want %b (grant %0d)", req_ready, exp_g, ngr);
        end
        if (exp_g == 2'b01) sb.push_back('{owner: 2'b01, res: 24'h000000, fl: 3'b010});
        else                sb.push_back('{owner: 2'b10, res: 24'h000000, fl: 3'b110});
        ngr++;
      end
    end
    @(negedge clk); req_valid = 2'b00; rsp_ready = 2'b00;
    n_cmp++;
    if (ngr !== 4 || sb.size() != 0) begin
      n_err++; $display("FAIL cont_count: got grants=%0d pending=%0d want 4 0", ngr, sb.size());
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    @(negedge clk);
    req_valid = 2'b01; req_a0 = 24'hF0F0F0; req_b0 = 24'hFF00FF; req_op0 = AND; #1;
    n_cmp++;
    if (req_ready !== 2'b01) begin
      n_err++; $display("FAIL bp_ready0: got %b want 01", req_ready);
    end
    sb.push_back('{owner: 2'b01, res: 24'hF000F0, fl: 3'b001});
    @(negedge clk);
    req_valid = 2'b11; req_a1 = 24'h123456; req_b1 = 24'h00FFFF; req_op1 = XOR; #1;
    n_cmp++;
    if ({req_ready, busy} !== 3'b001) begin
      n_err++; $display("FAIL bp_issue_wait: got rr=%b busy=%b want 00 1", req_ready, busy);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); rsp_ready = 2'b10; #1;
      n_cmp++;
      if ({rsp_valid, rsp_result, rsp_flags, req_ready, busy} !==
          {2'b01, 24'hF000F0, 3'b001, 2'b00, 1'b1}) begin
        n_err++; $display("FAIL bp_hold: got rv=%b res=%h fl=%b rr=%b busy=%b want 01 f000f0 001 00 1 (cycle %0d)",
                          rsp_valid, rsp_result, rsp_flags, req_ready, busy, k);
      end
    end
    @(negedge clk); rsp_ready = 2'b01; #1;
    n_cmp++;
    if (req_ready !== 2'b00) begin
      n_err++; $display("FAIL bp_consume_no_accept: got %b want 00", req_ready);
    end
    e = sb.pop_front();
    n_cmp++;
    if ({rsp_valid, rsp_result, rsp_flags} !== {e.owner, e.res, e.fl}) begin
      n_err++; $display("FAIL bp_rsp0: got %b %h %b want %b %h %b",
                        rsp_valid, rsp_result, rsp_flags, e.owner, e.res, e.fl);
    end
    @(negedge clk); rsp_ready = 2'b00; #1;
    n_cmp++;
    if (req_ready !== 2'b10) begin
      n_err++; $display("FAIL bp_grant1: got %b want 10", req_ready);
    end
    sb.push_back('{owner: 2'b10, res: 24'h12CBA9, fl: 3'b000});
    @(negedge clk); req_valid = 2'b00;
    @(negedge clk); rsp_ready = 2'b10; #1;
    e = sb.pop_front();
    n_cmp++;
    if ({rsp_valid, rsp_result, rsp_flags} !== {e.owner, e.res, e.fl}) begin
      n_err++; $display("FAIL bp_rsp1: got %b %h %b want %b %h %b",
                        rsp_valid, rsp_result, rsp_flags, e.owner, e.res, e.fl);
    end
    @(negedge clk); rsp_ready = 2'b00;
  endtask

  task automatic test_reset_mid;
    exp_t e;
    logic [83:0] obs;
    @(negedge clk);
    req_valid = 2'b01; req_a0 = 24'd1; req_b0 = 24'd1; req_op0 = ADD; rsp_ready = 2'b11;
    @(negedge clk); req_valid = 2'b00; #1;
    n_cmp++;
    if ({busy, alu_a} !== {1'b1, 24'd1}) begin
      n_err++; $display("FAIL rm_issue: got busy=%b a=%h want 1 000001", busy, alu_a);
    end
    rst_n = 1'b0; #1;
    obs = {req_ready, rsp_valid, rsp_result, rsp_flags, alu_a, alu_b, alu_sel, busy, alu_carry_in};
    n_cmp++;
    if (obs !== 84'd0) begin
      n_err++; $display("FAIL rm_outputs: got %h want 0", obs);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    n_cmp++;
    if ({rsp_valid, busy} !== 3'b000) begin
      n_err++; $display("FAIL rm_no_rsp: got rv=%b busy=%b want 00 0", rsp_valid, busy);
    end
    @(negedge clk);
    req_valid = 2'b11; req_a0 = 24'd1; req_b0 = 24'd1; req_op0 = ADD;
    req_a1 = 24'h00000F; req_b1 = 24'h0000F0; req_op1 = OR; #1;
    n_cmp++;
    if (req_ready !== 2'b01) begin
      n_err++; $display("FAIL rm_tie: got %b want 01", req_ready);
    end
    sb.push_back('{owner: 2'b01, res: 24'h000002, fl: 3'b000});
    @(negedge clk); req_valid = 2'b00;
    @(negedge clk); #1;
    e = sb.pop_front();
    n_cmp++;
    if ({rsp_valid, rsp_result, rsp_flags} !== {e.owner, e.res, e.fl}) begin
      n_err++; $display("FAIL rm_rsp: got %b %h %b want %b %h %b",
                        rsp_valid, rsp_result, rsp_flags, e.owner, e.res, e.fl);
    end
    @(negedge clk); rsp_ready = 2'b00; #1;
    n_cmp++;
    if ({busy, rsp_valid} !== 3'b000) begin
      n_err++; $display("FAIL rm_done: got busy=%b rv=%b want 0 00", busy, rsp_valid);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_add();
    test_sub_drop();
    test_contention();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
